// File: rtl/regfile_pkg.sv
// +--------------------------------------------------------------------------+
// | regfile_pkg: preload image, init helper and read-port bounds.    rev 1.0 |
// +--------------------------------------------------------------------------+
`default_nettype none

package regfile_pkg;

  localparam int NRD_MIN   = 1;
  localparam int NRD_MAX   = 4;
  localparam int PRELOAD_N = 16;

  localparam logic [15:0] PRELOAD [PRELOAD_N] = '{
    16'h0000, 16'h0F00, 16'h0050, 16'hFF0F,
    16'hF0FF, 16'h0040, 16'h0024, 16'h00FF,
    16'hAAAA, 16'h0000, 16'h0000, 16'h0000,
    16'hFFFF, 16'h0002, 16'h0000, 16'h0000
  };

  // Zero-extends the 16-bit image, masks to data_w, and yields 0 past the image.
  function automatic logic [63:0] init_val(input int idx, input int data_w);
    logic [63:0] v;
    v = '0;
    if (idx >= 0 && idx < PRELOAD_N) v[15:0] = PRELOAD[idx[3:0]];
    if (data_w < 64) v = v & ((64'd1 << data_w) - 64'd1);
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_sb_scoreboard.sv
// +--------------------------------------------------------------------------+
// | regfile_scoreboard: per-register busy bits, reserve beats clear. rev 1.0 |
// +--------------------------------------------------------------------------+
`default_nettype none

module regfile_scoreboard #(
  parameter int ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we_i,
  input  logic [ADDR_W-1:0]      wa_i,
  input  logic                   r0_we_i,
  input  logic                   rsv_en_i,
  input  logic [ADDR_W-1:0]      rsv_a_i,
  output logic [2**ADDR_W-1:0]   busy_o,
  output logic                   busy_any_o
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Reservation is applied last so a new producer wins over a retiring write.
  always_comb begin
    busy_d = busy_q;
    if (we_i)     busy_d[wa_i]    = 1'b0;
    if (r0_we_i)  busy_d[0]       = 1'b0;
    if (rsv_en_i) busy_d[rsv_a_i] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  assign busy_o     = busy_q;
  assign busy_any_o = |busy_q;

endmodule

`default_nettype wire

// File: rtl/regfile_sb.sv
// +--------------------------------------------------------------------------+
// | regfile_sb: N-read register file with R0 port, bypass, scoreboard. r1.0 |
// +--------------------------------------------------------------------------+
`default_nettype none

module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NRD*ADDR_W-1:0]   ra,
  output logic [NRD*DATA_W-1:0]   rd,
  output logic [NRD-1:0]          rbusy,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       wa,
  input  logic [DATA_W-1:0]       wd,
  input  logic                    r0_we,
  input  logic [DATA_W-1:0]       r0_wd,
  output logic [DATA_W-1:0]       r0_q,
  input  logic                    rsv_en,
  input  logic [ADDR_W-1:0]       rsv_a,
  output logic                    busy_any
);

  localparam int DEPTH = 2**ADDR_W;
  localparam bit BYP   = (BYPASS != 0);

  if (NRD < NRD_MIN || NRD > NRD_MAX) begin : g_nrd_check
    $error("regfile_sb: NRD outside supported range");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;

  // R0 port is written after the general port, so it wins a collision on entry 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= DATA_W'(init_val(i, DATA_W));
    end else begin
      if (we)    mem_q[wa] <= wd;
      if (r0_we) mem_q[0]  <= r0_wd;
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .we_i       (we),
    .wa_i       (wa),
    .r0_we_i    (r0_we),
    .rsv_en_i   (rsv_en),
    .rsv_a_i    (rsv_a),
    .busy_o     (busy_q),
    .busy_any_o (busy_any)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              hit_r0;
    logic              hit_w;
    logic [DATA_W-1:0] rd_k;
    logic              rbusy_k;

    assign addr = ra[k*ADDR_W +: ADDR_W];

    // Forwarding is suppressed while reset is held so outputs show the preload image.
    always_comb begin
      hit_r0  = BYP && rst && r0_we && (addr == '0);
      hit_w   = BYP && rst && we && (addr == wa);
      rd_k    = mem_q[addr];
      rbusy_k = busy_q[addr];
      if (hit_r0)     rd_k = r0_wd;
      else if (hit_w) rd_k = wd;
      if (hit_r0 || hit_w) rbusy_k = rsv_en && (rsv_a == addr);
    end

    assign rd[k*DATA_W +: DATA_W] = rd_k;
    assign rbusy[k]               = rbusy_k;
  end

  assign r0_q = mem_q[0];

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// +--------------------------------------------------------------------------+
// | tb_regfile_sb: random + directed bench for three regfile_sb variants. r1 |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0, r0_we = 1'b0, rsv_en = 1'b0;
  logic [3:0]  wa = '0, rsv_a = '0;
  logic [31:0] wd = '0, r0_wd = '0;
  logic [7:0]  ra_ab = '0;
  logic [11:0] ra_c = '0;

  logic [31:0] rd_a, rd_b;
  logic [95:0] rd_c;
  logic [1:0]  rb_a, rb_b;
  logic [2:0]  rb_c;
  logic [15:0] r0q_a, r0q_b;
  logic [31:0] r0q_c;
  logic        ba_a, ba_b, ba_c;

  int checks = 0;
  int errors = 0;
  bit run    = 1'b0;

  logic [31:0] mem [16];
  bit          busy [16];

  localparam logic [15:0] PRE [16] = '{
    16'h0000, 16'h0F00, 16'h0050, 16'hFF0F, 16'hF0FF, 16'h0040, 16'h0024, 16'h00FF,
    16'hAAAA, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0002, 16'h0000, 16'h0000
  };

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(16), .ADDR_W(4), .NRD(2), .BYPASS(1)) u_a (
    .clk(clk), .rst(rst), .ra(ra_ab), .rd(rd_a), .rbusy(rb_a),
    .we(we), .wa(wa), .wd(wd[15:0]), .r0_we(r0_we), .r0_wd(r0_wd[15:0]),
    .r0_q(r0q_a), .rsv_en(rsv_en), .rsv_a(rsv_a), .busy_any(ba_a));

  regfile_sb #(.DATA_W(16), .ADDR_W(4), .NRD(2), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .ra(ra_ab), .rd(rd_b), .rbusy(rb_b),
    .we(we), .wa(wa), .wd(wd[15:0]), .r0_we(r0_we), .r0_wd(r0_wd[15:0]),
    .r0_q(r0q_b), .rsv_en(rsv_en), .rsv_a(rsv_a), .busy_any(ba_b));

  regfile_sb #(.DATA_W(32), .ADDR_W(4), .NRD(3), .BYPASS(1)) u_c (
    .clk(clk), .rst(rst), .ra(ra_c), .rd(rd_c), .rbusy(rb_c),
    .we(we), .wa(wa), .wd(wd), .r0_we(r0_we), .r0_wd(r0_wd),
    .r0_q(r0q_c), .rsv_en(rsv_en), .rsv_a(rsv_a), .busy_any(ba_c));

  task automatic chk(input string nm, input int port, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h want %h at %0t", nm, port, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      mem[i]  = {16'h0000, PRE[i]};
      busy[i] = 1'b0;
    end
  endfunction

  function automatic void model_step();
    if (!rst) return;
    if (we)     begin mem[wa] = wd;    busy[wa] = 1'b0; end
    if (r0_we)  begin mem[0]  = r0_wd; busy[0]  = 1'b0; end
    if (rsv_en) busy[rsv_a] = 1'b1;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [3:0] a, input bit byp);
    if (byp && rst && r0_we && a == 4'd0) return r0_wd;
    if (byp && rst && we && a == wa)      return wd;
    return mem[a];
  endfunction

  function automatic logic [31:0] exp_rbusy(input logic [3:0] a, input bit byp);
    if (byp && rst && ((r0_we && a == 4'd0) || (we && a == wa)))
      return {31'd0, rsv_en && rsv_a == a};
    return {31'd0, busy[a]};
  endfunction

  function automatic logic [31:0] exp_any();
    bit any = 1'b0;
    for (int i = 0; i < 16; i++) any |= busy[i];
    return {31'd0, any};
  endfunction

  always @(negedge clk) begin
    if (run) begin
      for (int k = 0; k < 2; k++) begin
        chk("A.rd",    k, {16'h0, rd_a[k*16 +: 16]}, exp_rd(ra_ab[k*4 +: 4], 1'b1) & 32'hFFFF);
        chk("A.rbusy", k, {31'd0, rb_a[k]},          exp_rbusy(ra_ab[k*4 +: 4], 1'b1));
        chk("B.rd",    k, {16'h0, rd_b[k*16 +: 16]}, exp_rd(ra_ab[k*4 +: 4], 1'b0) & 32'hFFFF);
        chk("B.rbusy", k, {31'd0, rb_b[k]},          exp_rbusy(ra_ab[k*4 +: 4], 1'b0));
      end
      for (int k = 0; k < 3; k++) begin
        chk("C.rd",    k, rd_c[k*32 +: 32],  exp_rd(ra_c[k*4 +: 4], 1'b1));
        chk("C.rbusy", k, {31'd0, rb_c[k]},  exp_rbusy(ra_c[k*4 +: 4], 1'b1));
      end
      chk("A.r0_q", 0, {16'h0, r0q_a}, mem[0] & 32'hFFFF);
      chk("B.r0_q", 0, {16'h0, r0q_b}, mem[0] & 32'hFFFF);
      chk("C.r0_q", 0, r0q_c,          mem[0]);
      chk("A.busy_any", 0, {31'd0, ba_a}, exp_any());
      chk("B.busy_any", 0, {31'd0, ba_b}, exp_any());
      chk("C.busy_any", 0, {31'd0, ba_c}, exp_any());
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    we = 1'b0; r0_we = 1'b0; rsv_en = 1'b0;
  endtask

  initial begin
    model_reset();
    ra_ab = {4'd8, 4'd1};
    ra_c  = {4'd3, 4'd2, 4'd1};
    run   = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    chk("lit.reset.rd0", 0, {16'h0, rd_a[15:0]},  32'h0F00);
    chk("lit.reset.rd1", 1, {16'h0, rd_a[31:16]}, 32'hAAAA);
    chk("lit.reset.r0q", 0, {16'h0, r0q_a},       32'h0000);
    chk("lit.reset.any", 0, {31'd0, ba_a},        32'h0);

    // Same-cycle write and read of R3.
    tick();
    we = 1'b1; wa = 4'd3; wd = 32'h0000_1234; ra_ab = {4'd8, 4'd3};
    #1;
    chk("lit.byp1.rd", 0, {16'h0, rd_a[15:0]}, 32'h1234);
    chk("lit.byp0.rd", 0, {16'h0, rd_b[15:0]}, 32'hFF0F);
    tick();
    idle();
    #1;
    chk("lit.byp0.next", 0, {16'h0, rd_b[15:0]}, 32'h1234);

    // R0 collision.
    we = 1'b1; wa = 4'd0; wd = 32'h5555; r0_we = 1'b1; r0_wd = 32'h00AA;
    tick();
    idle();
    #1;
    chk("lit.coll.r0q_a", 0, {16'h0, r0q_a}, 32'h00AA);
    chk("lit.coll.r0q_c", 0, r0q_c,          32'h0000_00AA);

    // Reserve R5, hold, then retire it.
    rsv_en = 1'b1; rsv_a = 4'd5; ra_ab = {4'd5, 4'd5};
    tick();
    idle();
    for (int n = 0; n < 3; n++) begin
      #1;
      chk("lit.rsv.rbusy", n, {31'd0, rb_a[0]}, 32'h1);
      chk("lit.rsv.any",   n, {31'd0, ba_a},    32'h1);
      tick();
    end
    we = 1'b1; wa = 4'd5; wd = 32'h0007;
    tick();
    idle();
    #1;
    chk("lit.ret.rbusy", 0, {31'd0, rb_a[0]},     32'h0);
    chk("lit.ret.rd",    0, {16'h0, rd_a[15:0]},  32'h0007);
    chk("lit.ret.any",   0, {31'd0, ba_a},        32'h0);

    // Write and reserve R6 on the same edge.
    we = 1'b1; wa = 4'd6; wd = 32'hBEEF; rsv_en = 1'b1; rsv_a = 4'd6; ra_ab = {4'd6, 4'd6};
    tick();
    idle();
    #1;
    chk("lit.wr_rsv.rd",    0, {16'h0, rd_a[15:0]}, 32'hBEEF);
    chk("lit.wr_rsv.rbusy", 0, {31'd0, rb_b[0]},    32'h1);

    // Reserve R2, then pulse reset mid-cycle while a write to R4 is pending.
    rsv_en = 1'b1; rsv_a = 4'd2;
    tick();
    rsv_en = 1'b1; rsv_a = 4'd7; we = 1'b1; wa = 4'd4; wd = 32'h1111;
    ra_ab = {4'd4, 4'd2}; ra_c = {4'd3, 4'd3, 4'd3};
    #1;
    chk("lit.pre_rst.any", 0, {31'd0, ba_a}, 32'h1);
    rst = 1'b0;
    model_reset();
    #1;
    chk("lit.rst.r2",  0, {16'h0, rd_a[15:0]},  32'h0050);
    chk("lit.rst.r4",  1, {16'h0, rd_a[31:16]}, 32'hF0FF);
    chk("lit.rst.rb",  0, {30'd0, rb_a},        32'h0);
    chk("lit.rst.any", 0, {31'd0, ba_a},        32'h0);
    for (int k = 0; k < 3; k++) chk("lit.rst.c_r3", k, rd_c[k*32 +: 32], 32'h0000_FF0F);
    rst = 1'b1;

    // Randomized traffic with occasional mid-cycle resets.
    for (int n = 0; n < 600; n++) begin
      tick();
      we     = 1'($urandom_range(0, 1));
      wa     = 4'($urandom_range(0, 15));
      wd     = $urandom;
      r0_we  = ($urandom_range(0, 3) == 0);
      r0_wd  = $urandom;
      rsv_en = ($urandom_range(0, 2) == 0);
      rsv_a  = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      for (int k = 0; k < 2; k++) begin
        case ($urandom_range(0, 3))
          0:       ra_ab[k*4 +: 4] = wa;
          1:       ra_ab[k*4 +: 4] = 4'd0;
          2:       ra_ab[k*4 +: 4] = rsv_a;
          default: ra_ab[k*4 +: 4] = 4'($urandom_range(0, 15));
        endcase
      end
      for (int k = 0; k < 3; k++) begin
        case ($urandom_range(0, 3))
          0:       ra_c[k*4 +: 4] = wa;
          1:       ra_c[k*4 +: 4] = 4'd0;
          2:       ra_c[k*4 +: 4] = rsv_a;
          default: ra_c[k*4 +: 4] = 4'($urandom_range(0, 15));
        endcase
      end
      if (n % 97 == 50) begin
        #1;
        rst = 1'b0;
        model_reset();
        #2;
        rst = 1'b1;
      end
    end

    tick();
    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
